bean_map_ctrl: RTL and testbench
================================

BEAN_MAP_CTRL -- requirements
Module: bean_map_ctrl

Interface
REQ-001 Parameters SHALL be: COLS, default 40, tiles per row; ROWS, default 30, tile rows; TILE_LG2, default 4, log2 of tile edge in pixels; BEAN_R2, default 16, squared radius of a normal bean; PELLET_R2, default 36, squared radius of a power pellet; CNT_W, default 11, width of the remaining-item counter.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  system clock
  rst  in  1  asynchronous, active-high reset
  init_map  in  2*COLS*ROWS  initial cell codes, cell i at bits [2i+1:2i]
  load_start  in  1  one-cycle pulse that starts a map reload
  loading  out  1  high while a reload is in progress
  eat_valid  in  1  eat request
  eat_col  in  $clog2(COLS)  tile column of the eater
  eat_row  in  $clog2(ROWS)  tile row of the eater
  eat_ready  out  1  accepts an eat request when high
  ate_bean  out  1  one-cycle pulse: a bean was consumed
  ate_pellet  out  1  one-cycle pulse: a pellet was consumed
  remaining  out  CNT_W  count of live beans plus pellets
  map_clear  out  1  high when remaining is 0 and loading is low
  pix_x  in  10  pixel x query
  pix_y  in  9  pixel y query
  pix_bean  out  1  query pixel lies inside a live bean
  pix_pellet  out  1  query pixel lies inside a live pellet

Function
REQ-003 Each cell SHALL hold a 2-bit code: 0 empty, 1 bean, 2 pellet, 3 treated as empty.
REQ-004 The FSM SHALL have states IDLE, LOAD and EAT.
REQ-005 A load_start pulse in any state SHALL enter LOAD, abandon any pending eat, and set the row index to 0.
REQ-006 LOAD SHALL copy one row of init_map per cycle and add that row's count of codes 1 and 2 into remaining; remaining SHALL be zeroed on the entry cycle, and the state SHALL return to IDLE after row ROWS-1, so a reload takes exactly ROWS cycles.
REQ-007 loading SHALL be high exactly while in LOAD.
REQ-008 eat_ready SHALL be high only in IDLE.
REQ-009 eat_valid with eat_ready high SHALL capture eat_col and eat_row and enter EAT.
REQ-010 EAT SHALL last one cycle and then return to IDLE; a live cell SHALL be cleared to 0 and remaining decremented; ate_bean or ate_pellet SHALL pulse in the cycle after EAT; an empty cell SHALL produce no pulse and no change.
REQ-011 An eat request with eat_col >= COLS or eat_row >= ROWS SHALL be accepted and ignored.
REQ-012 remaining SHALL saturate at 0 and never wrap.
REQ-013 The pixel query SHALL be a 2-stage pipeline, so results for inputs at cycle n are valid at n+2.
REQ-014 Stage 1 SHALL register the tile column (pix_x >> TILE_LG2), the tile row, and the in-tile offsets dx and dy relative to the tile centre (2^(TILE_LG2-1)) as signed values.
REQ-015 Stage 2 SHALL compute dx*dx + dy*dy and assert pix_bean if the code is 1 and the sum <= BEAN_R2, or pix_pellet if the code is 2 and the sum <= PELLET_R2.
REQ-016 Pixels outside COLS*2^TILE_LG2 by ROWS*2^TILE_LG2 SHALL produce 0.
REQ-017 When an eat and a query hit the same cell in the same cycle, the query SHALL see the pre-eat value.
REQ-018 During LOAD the query outputs SHALL be forced to 0.

Reset
REQ-019 Asserting rst SHALL, asynchronously, set the state to IDLE, clear all cells to 0, set remaining to 0, and set loading, ate_bean, ate_pellet, pix_bean and pix_pellet to 0; map_clear then reads 1.
REQ-020 Reset asserted mid-LOAD or mid-EAT SHALL abort it; no pulse SHALL emerge after release.

Structure
REQ-021 Cell code constants, FSM state encodings and the default geometry parameters SHALL live in the shared package pacman_pkg.
REQ-022 The row popcount SHALL be the sub-module bean_row_count (input COLS*2 bits, output count).
REQ-023 Cell storage SHALL be flip-flops with one write port and an asynchronous read for the query.

Verification
REQ-024 Reset, then load_start with init_map all beans -> loading high for 30 cycles, then remaining=1200 and map_clear=0.
REQ-025 After a load with a pellet at (3,2), eat_valid col=3 row=2 -> ate_pellet pulses 2 cycles after acceptance, remaining decreases by 1, and a repeat eat gives no pulse.
REQ-026 With cell (0,0)=bean, pix (8,8) -> pix_bean=1 two cycles later; pix (12,8) gives 1 (sum 16); pix (13,8) gives 0 (sum 25).
REQ-027 Eat requests for col=40 and for an empty cell -> no pulse, remaining unchanged; eat_valid during LOAD -> not accepted (eat_ready=0).
REQ-028 Map with a single bean, eat it -> map_clear=1; then load_start mid-way through a second load followed by rst -> all outputs 0 and no stray pulse.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared definitions for the bean map: cell codes, controller state
// encodings, default geometry, and a helper classifying live cells.
package pacman_pkg;

   localparam int DEF_COLS      = 40;
   localparam int DEF_ROWS      = 30;
   localparam int DEF_TILE_LG2  = 4;
   localparam int DEF_BEAN_R2   = 16;
   localparam int DEF_PELLET_R2 = 36;
   localparam int DEF_CNT_W     = 11;

   typedef enum logic [1:0] {
      CELL_EMPTY  = 2'd0,
      CELL_BEAN   = 2'd1,
      CELL_PELLET = 2'd2,
      CELL_RSVD   = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EAT  = 2'd2
   } state_t;

   // Code 3 is treated as empty, so only beans and pellets are live.
   function automatic logic is_live(input logic [1:0] code);
      return (code == CELL_BEAN) || (code == CELL_PELLET);
   endfunction

endpackage

// File: rtl/bean_row_count.sv
// Counts the live cells (beans plus pellets) in one row of cell codes.
// Ports:
//   row   - COLS packed 2-bit cell codes, cell i at bits [2i+1:2i]
//   count - number of cells holding code 1 or 2
module bean_row_count
   import pacman_pkg::*;
#(
   parameter int COLS = DEF_COLS,
   parameter int CW   = $clog2(COLS + 1)
) (
   input  logic [2*COLS-1:0] row,
   output logic [CW-1:0]     count
);

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < COLS; i++) begin
         if (is_live(row[2*i +: 2])) count = count + CW'(1);
      end
   end

endmodule

// File: rtl/bean_map_ctrl.sv
// Bean/pellet map controller: holds the tile map in flip-flops, reloads it
// one row per cycle, services eat requests, and answers a pipelined
// pixel-in-bean query for the renderer.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   init_map, load_start  - map image and reload trigger
//   loading               - high while a reload is running
//   eat_valid/col/row     - eat request; eat_ready accepts it
//   ate_bean, ate_pellet  - one-cycle pulses when an item is consumed
//   remaining, map_clear  - live item count, all-eaten flag
//   pix_x, pix_y          - pixel query; pix_bean/pix_pellet two cycles later
module bean_map_ctrl
   import pacman_pkg::*;
#(
   parameter int COLS      = DEF_COLS,
   parameter int ROWS      = DEF_ROWS,
   parameter int TILE_LG2  = DEF_TILE_LG2,
   parameter int BEAN_R2   = DEF_BEAN_R2,
   parameter int PELLET_R2 = DEF_PELLET_R2,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2*COLS*ROWS-1:0]    init_map,
   input  logic                      load_start,
   output logic                      loading,
   input  logic                      eat_valid,
   input  logic [$clog2(COLS)-1:0]   eat_col,
   input  logic [$clog2(ROWS)-1:0]   eat_row,
   output logic                      eat_ready,
   output logic                      ate_bean,
   output logic                      ate_pellet,
   output logic [CNT_W-1:0]          remaining,
   output logic                      map_clear,
   input  logic [9:0]                pix_x,
   input  logic [8:0]                pix_y,
   output logic                      pix_bean,
   output logic                      pix_pellet
);

   localparam int CW  = $clog2(COLS);
   localparam int RW  = $clog2(ROWS);
   localparam int NC  = COLS * ROWS;
   localparam int RCW = $clog2(COLS + 1);
   localparam int TXW = 10 - TILE_LG2;
   localparam int TYW = 9 - TILE_LG2;
   localparam int DW  = TILE_LG2 + 1;
   localparam int SW  = 2 * TILE_LG2 + 3;
   localparam logic signed [DW-1:0] HALF = DW'(2 ** (TILE_LG2 - 1));

   state_t          state;
   logic [2*NC-1:0] cells;
   logic [RW-1:0]   ridx;
   logic [CW-1:0]   ecol;
   logic [RW-1:0]   erow;

   logic [2*COLS-1:0] load_row;
   logic [RCW-1:0]    row_cnt;
   int unsigned       eidx;
   logic [1:0]        ecode;

   always_comb load_row = init_map[int'(ridx)*2*COLS +: 2*COLS];

   bean_row_count #(.COLS(COLS), .CW(RCW)) u_row_count (
      .row   (load_row),
      .count (row_cnt)
   );

   // Out-of-range eat coordinates read as empty, so they are silently dropped.
   always_comb begin
      eidx  = 0;
      ecode = CELL_EMPTY;
      if (int'(ecol) < COLS && int'(erow) < ROWS) begin
         eidx  = int'(erow) * COLS + int'(ecol);
         ecode = cells[2*eidx +: 2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cells      <= '0;
         ridx       <= '0;
         ecol       <= '0;
         erow       <= '0;
         remaining  <= '0;
         loading    <= 1'b0;
         ate_bean   <= 1'b0;
         ate_pellet <= 1'b0;
      end else begin
         ate_bean   <= 1'b0;
         ate_pellet <= 1'b0;
         if (load_start) begin
            state     <= ST_LOAD;
            loading   <= 1'b1;
            ridx      <= '0;
            remaining <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (eat_valid) begin
                     ecol  <= eat_col;
                     erow  <= eat_row;
                     state <= ST_EAT;
                  end
               end
               ST_LOAD: begin
                  cells[int'(ridx)*2*COLS +: 2*COLS] <= load_row;
                  remaining <= remaining + CNT_W'(row_cnt);
                  if (int'(ridx) == ROWS - 1) begin
                     state   <= ST_IDLE;
                     loading <= 1'b0;
                  end else begin
                     ridx <= ridx + RW'(1);
                  end
               end
               ST_EAT: begin
                  if (is_live(ecode)) begin
                     cells[2*eidx +: 2] <= CELL_EMPTY;
                     if (remaining != '0) remaining <= remaining - CNT_W'(1);
                     ate_bean   <= (ecode == CELL_BEAN);
                     ate_pellet <= (ecode == CELL_PELLET);
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign eat_ready = (state == ST_IDLE);
   assign map_clear = (remaining == '0) && !loading;

   // Query stage 1: tile coordinates and signed offsets from the tile centre.
   logic [TXW-1:0]        s1_tx;
   logic [TYW-1:0]        s1_ty;
   logic signed [DW-1:0]  s1_dx, s1_dy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_tx <= '0;
         s1_ty <= '0;
         s1_dx <= '0;
         s1_dy <= '0;
      end else begin
         s1_tx <= pix_x[9:TILE_LG2];
         s1_ty <= pix_y[8:TILE_LG2];
         s1_dx <= $signed({1'b0, pix_x[TILE_LG2-1:0]}) - HALF;
         s1_dy <= $signed({1'b0, pix_y[TILE_LG2-1:0]}) - HALF;
      end
   end

   // Query stage 2: the cell is read combinationally here and the result is
   // registered on the same edge an eat would write it, so a coincident eat
   // is not yet visible to the query.
   logic                  q_hit;
   int unsigned           qidx;
   logic [1:0]            qcode;
   logic signed [SW-1:0]  dxe, dye;
   logic [SW-1:0]         sq;

   always_comb begin
      q_hit = (int'(s1_tx) < COLS) && (int'(s1_ty) < ROWS);
      qidx  = 0;
      qcode = CELL_EMPTY;
      if (q_hit) begin
         qidx  = int'(s1_ty) * COLS + int'(s1_tx);
         qcode = cells[2*qidx +: 2];
      end
      dxe = SW'(s1_dx);
      dye = SW'(s1_dy);
      sq  = dxe * dxe + dye * dye;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_bean   <= 1'b0;
         pix_pellet <= 1'b0;
      end else if (state == ST_LOAD || load_start) begin
         pix_bean   <= 1'b0;
         pix_pellet <= 1'b0;
      end else begin
         pix_bean   <= (qcode == CELL_BEAN)   && (sq <= SW'(BEAN_R2));
         pix_pellet <= (qcode == CELL_PELLET) && (sq <= SW'(PELLET_R2));
      end
   end

endmodule

// File: tb/tb_bean_map_ctrl.sv
// Directed bench for bean_map_ctrl: a pixel-query vector table plus
// hand-written sequences for load, eat, restart and reset corner cases.
module tb_bean_map_ctrl;

   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int NC   = COLS * ROWS;

   logic                 clk;
   logic                 rst;
   logic [2*NC-1:0]      init_map;
   logic                 load_start;
   logic                 loading;
   logic                 eat_valid;
   logic [5:0]           eat_col;
   logic [4:0]           eat_row;
   logic                 eat_ready;
   logic                 ate_bean;
   logic                 ate_pellet;
   logic [10:0]          remaining;
   logic                 map_clear;
   logic [9:0]           pix_x;
   logic [8:0]           pix_y;
   logic                 pix_bean;
   logic                 pix_pellet;

   bean_map_ctrl #(
      .COLS(40), .ROWS(30), .TILE_LG2(4), .BEAN_R2(16), .PELLET_R2(36), .CNT_W(11)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .init_map   (init_map),
      .load_start (load_start),
      .loading    (loading),
      .eat_valid  (eat_valid),
      .eat_col    (eat_col),
      .eat_row    (eat_row),
      .eat_ready  (eat_ready),
      .ate_bean   (ate_bean),
      .ate_pellet (ate_pellet),
      .remaining  (remaining),
      .map_clear  (map_clear),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_bean   (pix_bean),
      .pix_pellet (pix_pellet)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      name;
      logic [9:0] x;
      logic [8:0] y;
      logic       b;
      logic       p;
   } pv_t;

   pv_t pv[17];

   logic [2*NC-1:0] map_a, map_b, map_c;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic start_load(input logic [2*NC-1:0] m);
      init_map   = m;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic wait_load(output int cyc);
      cyc = 0;
      while (loading && cyc < 200) begin
         cyc++;
         tick();
      end
   endtask

   task automatic do_eat(input string nm, input int c, input int r, input logic eb, input logic ep);
      int w;
      w = 0;
      while (!eat_ready && w < 10) begin
         w++;
         tick();
      end
      check({nm, "_ready"}, 32'(eat_ready), 32'd1);
      eat_valid = 1'b1;
      eat_col   = 6'(c);
      eat_row   = 5'(r);
      tick();
      eat_valid = 1'b0;
      check({nm, "_early"}, {30'd0, ate_bean, ate_pellet}, 32'd0);
      tick();
      check({nm, "_pulse"}, {30'd0, ate_bean, ate_pellet}, {30'd0, eb, ep});
      tick();
      check({nm, "_after"}, {30'd0, ate_bean, ate_pellet}, 32'd0);
   endtask

   initial begin
      int cyc;
      logic seen;

      rst        = 1'b1;
      init_map   = '0;
      load_start = 1'b0;
      eat_valid  = 1'b0;
      eat_col    = '0;
      eat_row    = '0;
      pix_x      = '0;
      pix_y      = '0;

      map_a = '0;
      for (int i = 0; i < NC; i++) map_a[2*i +: 2] = 2'b01;
      map_b = map_a;
      map_b[2*(2*COLS+3) +: 2] = 2'b10;   // pellet at (3,2)
      map_b[2*(5*COLS+5) +: 2] = 2'b00;   // empty at (5,5)
      map_b[2*(5*COLS+6) +: 2] = 2'b11;   // code 3 at (6,5)
      map_c = '0;
      map_c[2*(3*COLS+7) +: 2] = 2'b01;   // lone bean at (7,3)

      pv[0]  = '{"bean_ctr",      10'd8,   9'd8,   1'b1, 1'b0};
      pv[1]  = '{"bean_dx4",      10'd12,  9'd8,   1'b1, 1'b0};
      pv[2]  = '{"bean_dx5",      10'd13,  9'd8,   1'b0, 1'b0};
      pv[3]  = '{"bean_dxm4",     10'd4,   9'd8,   1'b1, 1'b0};
      pv[4]  = '{"bean_dxm5",     10'd3,   9'd8,   1'b0, 1'b0};
      pv[5]  = '{"bean_dy4",      10'd8,   9'd12,  1'b1, 1'b0};
      pv[6]  = '{"pel_ctr",       10'd56,  9'd40,  1'b0, 1'b1};
      pv[7]  = '{"pel_dx6",       10'd62,  9'd40,  1'b0, 1'b1};
      pv[8]  = '{"pel_dx7",       10'd63,  9'd40,  1'b0, 1'b0};
      pv[9]  = '{"pel_34",        10'd61,  9'd43,  1'b0, 1'b1};
      pv[10] = '{"pel_25",        10'd59,  9'd44,  1'b0, 1'b1};
      pv[11] = '{"empty_cell",    10'd88,  9'd88,  1'b0, 1'b0};
      pv[12] = '{"code3_cell",    10'd104, 9'd88,  1'b0, 1'b0};
      pv[13] = '{"x_out",         10'd640, 9'd8,   1'b0, 1'b0};
      pv[14] = '{"y_out",         10'd8,   9'd480, 1'b0, 1'b0};
      pv[15] = '{"last_ctr",      10'd632, 9'd472, 1'b1, 1'b0};
      pv[16] = '{"last_corner",   10'd639, 9'd479, 1'b0, 1'b0};

      #22 rst = 1'b0;
      tick();

      // Reset state
      check("rst_remaining", 32'(remaining), 32'd0);
      check("rst_map_clear", 32'(map_clear), 32'd1);
      check("rst_loading",   32'(loading),   32'd0);
      check("rst_eat_ready", 32'(eat_ready), 32'd1);
      check("rst_pix",       {30'd0, pix_bean, pix_pellet}, 32'd0);
      check("rst_ate",       {30'd0, ate_bean, ate_pellet}, 32'd0);

      // Full load of beans
      start_load(map_a);
      wait_load(cyc);
      check("load_a_cycles",    32'(cyc),       32'd30);
      check("load_a_remaining", 32'(remaining), 32'd1200);
      check("load_a_map_clear", 32'(map_clear), 32'd0);

      // Mixed map and pixel table
      start_load(map_b);
      wait_load(cyc);
      check("load_b_cycles",    32'(cyc),       32'd30);
      check("load_b_remaining", 32'(remaining), 32'd1198);
      for (int i = 0; i < 17; i++) begin
         pix_x = pv[i].x;
         pix_y = pv[i].y;
         tick();
         tick();
         check({"pix_", pv[i].name, "_bean"},   32'(pix_bean),   32'(pv[i].b));
         check({"pix_", pv[i].name, "_pellet"}, 32'(pix_pellet), 32'(pv[i].p));
      end

      // Pellet eat, repeat, out-of-range, empty and code-3 cells
      do_eat("eat_pellet", 3, 2, 1'b0, 1'b1);
      check("eat_pellet_rem", 32'(remaining), 32'd1197);
      do_eat("eat_again", 3, 2, 1'b0, 1'b0);
      check("eat_again_rem", 32'(remaining), 32'd1197);
      do_eat("eat_col40", 40, 0, 1'b0, 1'b0);
      check("eat_col40_rem", 32'(remaining), 32'd1197);
      do_eat("eat_empty", 5, 5, 1'b0, 1'b0);
      do_eat("eat_code3", 6, 5, 1'b0, 1'b0);
      check("eat_empty_rem", 32'(remaining), 32'd1197);
      pix_x = 10'd56;
      pix_y = 9'd40;
      tick();
      tick();
      check("pix_eaten_pellet", {30'd0, pix_bean, pix_pellet}, 32'd0);

      // Eat and query of the same cell in the same cycle
      eat_valid = 1'b1;
      eat_col   = 6'd0;
      eat_row   = 5'd0;
      pix_x     = 10'd8;
      pix_y     = 9'd8;
      tick();
      eat_valid = 1'b0;
      tick();
      check("same_cycle_pix_pre",  32'(pix_bean),  32'd1);
      check("same_cycle_ate_bean", 32'(ate_bean),  32'd1);
      check("same_cycle_rem",      32'(remaining), 32'd1196);
      tick();
      check("same_cycle_pix_post", 32'(pix_bean),  32'd0);

      // Requests and queries during a load
      start_load(map_a);
      check("during_load_ready",   32'(eat_ready), 32'd0);
      check("during_load_loading", 32'(loading),   32'd1);
      eat_valid = 1'b1;
      eat_col   = 6'd1;
      eat_row   = 5'd0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen = seen | ate_bean | ate_pellet | pix_bean | pix_pellet | eat_ready;
      end
      eat_valid = 1'b0;
      check("during_load_quiet", 32'(seen), 32'd0);
      wait_load(cyc);
      tick();
      tick();
      check("during_load_rem",     32'(remaining), 32'd1200);
      check("during_load_no_eat",  {30'd0, ate_bean, ate_pellet}, 32'd0);

      // Lone bean map cleared by one eat
      start_load(map_c);
      wait_load(cyc);
      check("single_rem",      32'(remaining), 32'd1);
      check("single_clear0",   32'(map_clear), 32'd0);
      do_eat("single_eat", 7, 3, 1'b1, 1'b0);
      check("single_rem_zero", 32'(remaining), 32'd0);
      check("single_clear1",   32'(map_clear), 32'd1);

      // Restart mid-load restarts the count
      start_load(map_a);
      for (int i = 0; i < 9; i++) tick();
      start_load(map_a);
      wait_load(cyc);
      check("restart_cycles", 32'(cyc),       32'd30);
      check("restart_rem",    32'(remaining), 32'd1200);

      // Reset mid-load
      start_load(map_a);
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b1;
      #1;
      check("rst_load_loading", 32'(loading),   32'd0);
      check("rst_load_rem",     32'(remaining), 32'd0);
      check("rst_load_clear",   32'(map_clear), 32'd1);
      check("rst_load_pix",     {30'd0, pix_bean, pix_pellet}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 35; i++) begin
         tick();
         seen = seen | loading | ate_bean | ate_pellet | pix_bean | pix_pellet;
      end
      check("rst_load_quiet", 32'(seen),      32'd0);
      check("rst_load_rem2",  32'(remaining), 32'd0);

      // Reset mid-eat
      start_load(map_a);
      wait_load(cyc);
      eat_valid = 1'b1;
      eat_col   = 6'd0;
      eat_row   = 5'd0;
      tick();
      eat_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_eat_rem", 32'(remaining), 32'd0);
      tick();
      rst = 1'b0;
      pix_x = 10'd8;
      pix_y = 9'd8;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen = seen | ate_bean | ate_pellet | pix_bean | pix_pellet;
      end
      check("rst_eat_quiet", 32'(seen),      32'd0);
      check("rst_eat_ready", 32'(eat_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
